// File: rtl/score_keeper_pkg.sv
// Shared constants for the score keeper and the score/text renderer.
package score_keeper_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  // Ceiling log2: number of bits needed to hold n distinct values.
  function automatic int logb2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_keeper_edge_detect.sv
// Rising-edge pulse from a synchronous level; one-cycle pulse per 0->1 transition.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_level_q <= 1'b0;
    else        r_level_q <= i_level;
  end

  assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/score_keeper.sv
// Game state, score and high-score register stage feeding the score/"GAME OVER" renderer.
// Handshake: all inputs are single-cycle pulses or levels with no back-pressure; every output is a register.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter  int H           = 32,
  parameter  int V           = 32,
  parameter  int WIN_SCORE   = 1000,
  parameter  int HOLD_FRAMES = 60,
  localparam int SCORE_W     = logb2(H * V)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_frame_tick,
  input  logic               i_start,
  input  logic               i_food_eaten,
  input  logic               i_crash,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] o_high_score,
  output logic               o_game_over,
  output logic               o_playing,
  output logic               o_new_record,
  output logic [1:0]         o_state
);

  localparam int HOLD_W = (logb2(HOLD_FRAMES + 1) > 0) ? logb2(HOLD_FRAMES + 1) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W:0]   WIN_EXT   = (SCORE_W + 1)'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_FRAMES);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [SCORE_W-1:0] r_high;
  logic [SCORE_W-1:0] w_high_nxt;
  logic [HOLD_W-1:0]  r_hold;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic               r_new_record;
  logic               w_new_record_nxt;
  logic               r_game_over;
  logic               w_game_over_nxt;
  logic               r_playing;
  logic               w_playing_nxt;

  logic               w_start_rise;
  logic [SCORE_W:0]   w_score_plus;
  logic               w_win;
  logic               w_game_end;
  logic [SCORE_W-1:0] w_final_score;

  edge_detect u_start_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (i_start),
    .o_rise  (w_start_rise)
  );

  // Crash outranks food, so a win only counts when no crash arrives alongside it.
  assign w_score_plus  = {1'b0, r_score} + (SCORE_W + 1)'(1);
  assign w_win         = ~i_crash & i_food_eaten & (w_score_plus == WIN_EXT);
  assign w_game_end    = i_crash | w_win;
  assign w_final_score = w_win ? WIN_VAL : r_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_rise)    w_state_nxt = ST_RUN;
      ST_RUN:  if (w_game_end)      w_state_nxt = ST_HOLD;
      ST_HOLD: if (r_hold == '0)    w_state_nxt = ST_OVER;
      ST_OVER: if (w_start_rise)    w_state_nxt = ST_RUN;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_score_nxt      = r_score;
    w_high_nxt       = r_high;
    w_hold_nxt       = r_hold;
    w_new_record_nxt = r_new_record;
    w_game_over_nxt  = (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_OVER);
    w_playing_nxt    = (w_state_nxt == ST_RUN);
    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) w_score_nxt = '0;
      end
      ST_RUN: begin
        if (w_game_end) begin
          w_score_nxt = w_final_score;
          w_hold_nxt  = HOLD_INIT;
          if (w_final_score > r_high) begin
            w_high_nxt       = w_final_score;
            w_new_record_nxt = 1'b1;
          end else begin
            w_new_record_nxt = 1'b0;
          end
        end else if (i_food_eaten && (r_score != SCORE_MAX)) begin
          w_score_nxt = r_score + SCORE_W'(1);
        end
      end
      ST_HOLD: begin
        if ((r_hold != '0) && i_frame_tick) w_hold_nxt = r_hold - HOLD_W'(1);
      end
      ST_OVER: begin
        if (w_start_rise) begin
          w_score_nxt      = '0;
          w_new_record_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score      <= '0;
      r_high       <= '0;
      r_hold       <= '0;
      r_new_record <= 1'b0;
      r_game_over  <= 1'b0;
      r_playing    <= 1'b0;
    end else begin
      r_score      <= w_score_nxt;
      r_high       <= w_high_nxt;
      r_hold       <= w_hold_nxt;
      r_new_record <= w_new_record_nxt;
      r_game_over  <= w_game_over_nxt;
      r_playing    <= w_playing_nxt;
    end
  end

  assign o_score      = r_score;
  assign o_high_score = r_high;
  assign o_game_over  = r_game_over;
  assign o_playing    = r_playing;
  assign o_new_record = r_new_record;
  assign o_state      = r_state;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances (long lockout / small win threshold) against a cycle model.
module tb_score_keeper;
  import score_keeper_pkg::*;

  // Input vector bits: {start, food_eaten, crash, frame_tick}
  localparam logic [3:0] S = 4'b1000;
  localparam logic [3:0] F = 4'b0100;
  localparam logic [3:0] C = 4'b0010;
  localparam logic [3:0] T = 4'b0001;

  typedef struct {
    int phase;
    int score;
    int high;
    int go;
    int play;
    int rec;
    int hold;
    int start_q;
  } mdl_t;

  typedef struct {
    logic [3:0] in;
    int         exp_score;
    int         exp_go;
    int         exp_play;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a_in  = '0;
  logic [3:0] b_in  = '0;

  logic [9:0] a_score, a_high;
  logic       a_go, a_play, a_rec;
  logic [1:0] a_state;
  logic [2:0] b_score, b_high;
  logic       b_go, b_play, b_rec;
  logic [1:0] b_state;

  mdl_t ma, mb;
  vec_t vecs[15];
  int   n_checks = 0;
  int   n_err    = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  score_keeper #(.H(32), .V(32), .WIN_SCORE(1000), .HOLD_FRAMES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_frame_tick(a_in[0]), .i_start(a_in[3]), .i_food_eaten(a_in[2]), .i_crash(a_in[1]),
    .o_score(a_score), .o_high_score(a_high), .o_game_over(a_go),
    .o_playing(a_play), .o_new_record(a_rec), .o_state(a_state)
  );

  score_keeper #(.H(4), .V(2), .WIN_SCORE(4), .HOLD_FRAMES(0)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .i_frame_tick(b_in[0]), .i_start(b_in[3]), .i_food_eaten(b_in[2]), .i_crash(b_in[1]),
    .o_score(b_score), .o_high_score(b_high), .o_game_over(b_go),
    .o_playing(b_play), .o_new_record(b_rec), .o_state(b_state)
  );

  // ---------------- reference model ----------------
  function automatic mdl_t model_reset();
    mdl_t m;
    m.phase = ST_IDLE; m.score = 0; m.high = 0; m.go = 0;
    m.play = 0; m.rec = 0; m.hold = 0; m.start_q = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, logic [3:0] in, int win, int hold_frames, int smax);
    mdl_t n;
    int   fin;
    bit   done;
    bit   rise;
    n    = m;
    fin  = m.score;
    done = 1'b0;
    rise = in[3] && (m.start_q == 0);
    n.start_q = int'(in[3]);
    case (m.phase)
      ST_IDLE: if (rise) begin
        n.phase = ST_RUN; n.score = 0; n.play = 1;
      end
      ST_RUN: begin
        if (in[1]) begin
          done = 1'b1;
        end else if (in[2]) begin
          if (m.score + 1 == win) begin
            fin = win; n.score = win; done = 1'b1;
          end else begin
            n.score = (m.score < smax) ? m.score + 1 : smax;
          end
        end
        if (done) begin
          n.phase = ST_HOLD; n.go = 1; n.play = 0; n.hold = hold_frames;
          if (fin > m.high) begin
            n.high = fin; n.rec = 1;
          end else begin
            n.rec = 0;
          end
        end
      end
      ST_HOLD: begin
        if (m.hold == 0) n.phase = ST_OVER;
        else if (in[0])  n.hold = m.hold - 1;
      end
      default: if (rise) begin
        n.phase = ST_RUN; n.score = 0; n.go = 0; n.rec = 0; n.play = 1;
      end
    endcase
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("a_score", int'(a_score), ma.score);
    chk("a_high",  int'(a_high),  ma.high);
    chk("a_go",    int'(a_go),    ma.go);
    chk("a_play",  int'(a_play),  ma.play);
    chk("a_rec",   int'(a_rec),   ma.rec);
    chk("a_state", int'(a_state), ma.phase);
    chk("b_score", int'(b_score), mb.score);
    chk("b_high",  int'(b_high),  mb.high);
    chk("b_go",    int'(b_go),    mb.go);
    chk("b_play",  int'(b_play),  mb.play);
    chk("b_rec",   int'(b_rec),   mb.rec);
    chk("b_state", int'(b_state), mb.phase);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] a, input logic [3:0] b);
    a_in = a;
    b_in = b;
    @(posedge clk);
    ma = mstep(ma, a, 1000, 3, 1023);
    mb = mstep(mb, b, 4, 0, 7);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a_score", int'(a_score), 0);
    chk("arst_a_high",  int'(a_high),  0);
    chk("arst_a_go",    int'(a_go),    0);
    chk("arst_a_play",  int'(a_play),  0);
    chk("arst_a_rec",   int'(a_rec),   0);
    chk("arst_a_state", int'(a_state), int'(ST_IDLE));
    ma = model_reset();
    mb = model_reset();
    #2 rst_n = 1'b1;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [3:0] ra, rb;
    ma = model_reset();
    mb = model_reset();

    vecs[0] = '{S, 0, 0, 1};
    for (int k = 1; k < 15; k++) begin
      vecs[k].in        = (k >= 2 && (k - 2) % 3 == 0) ? F : 4'b0000;
      vecs[k].exp_score = (k >= 2) ? (k - 2) / 3 + 1 : 0;
      vecs[k].exp_go    = 0;
      vecs[k].exp_play  = 1;
    end

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("reset_score", int'(a_score), 0);
    chk("reset_high",  int'(a_high),  0);
    chk("reset_play",  int'(a_play),  0);
    chk("reset_go",    int'(a_go),    0);
    check_all();

    // start, then 5 food pulses 3 cycles apart
    for (int k = 0; k < 15; k++) begin
      step(vecs[k].in, 4'b0000);
      chk("vec_score", int'(a_score), vecs[k].exp_score);
      chk("vec_go",    int'(a_go),    vecs[k].exp_go);
      chk("vec_play",  int'(a_play),  vecs[k].exp_play);
    end

    // crash and food together: crash wins
    step(F | C, 4'b0000);
    chk("crashfood_score", int'(a_score), 5);
    chk("crashfood_go",    int'(a_go),    1);
    chk("crashfood_play",  int'(a_play),  0);
    chk("crashfood_high",  int'(a_high),  5);
    chk("crashfood_rec",   int'(a_rec),   1);

    // start pulses during lockout are ignored
    step(S, 0); step(0, 0); step(S, 0); step(0, 0);
    chk("hold_ignore_start", int'(a_state), int'(ST_HOLD));
    // start held through the lockout
    step(S, 0);
    step(S | T, 0); step(S, 0); step(S | T, 0); step(S, 0);
    chk("hold_after_2_ticks", int'(a_state), int'(ST_HOLD));
    step(S | T, 0);
    chk("hold_after_3_ticks", int'(a_state), int'(ST_HOLD));
    step(S, 0);
    chk("over_after_hold", int'(a_state), int'(ST_OVER));
    repeat (4) step(S, 0);
    chk("over_held_start", int'(a_state), int'(ST_OVER));
    chk("over_held_go",    int'(a_go),    1);
    step(0, 0);
    step(S, 0);
    chk("restart_score", int'(a_score), 0);
    chk("restart_go",    int'(a_go),    0);
    chk("restart_rec",   int'(a_rec),   0);
    chk("restart_high",  int'(a_high),  5);
    chk("restart_play",  int'(a_play),  1);

    // second game: lower score, no record
    step(0, 0); step(F, 0); step(0, 0); step(F, 0); step(0, 0); step(F, 0);
    chk("game2_score", int'(a_score), 3);
    step(C, 0);
    chk("game2_high", int'(a_high), 5);
    chk("game2_rec",  int'(a_rec),  0);
    chk("game2_go",   int'(a_go),   1);
    step(T, 0); step(T, 0); step(T, 0); step(0, 0);
    chk("game2_over", int'(a_state), int'(ST_OVER));

    // third game to score 7, then asynchronous reset
    step(S, 0); step(0, 0);
    repeat (7) step(F, 0);
    chk("game3_score", int'(a_score), 7);
    async_reset();
    repeat (3) step(F, 0);
    chk("post_rst_score", int'(a_score), 0);
    chk("post_rst_play",  int'(a_play),  0);
    step(S, 0);
    chk("post_rst_start", int'(a_play), 1);

    // win threshold on the second instance, zero-length lockout
    step(0, S); step(0, 0);
    step(0, F); step(0, F); step(0, F);
    chk("win_pre_go", int'(b_go), 0);
    step(0, F);
    chk("win_score", int'(b_score), 4);
    chk("win_go",    int'(b_go),    1);
    chk("win_state", int'(b_state), int'(ST_HOLD));
    step(0, 0);
    chk("win_over", int'(b_state), int'(ST_OVER));

    // randomized stimulus against the model
    ra = '0;
    rb = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ra[3] = ~ra[3];
      if ($urandom_range(0, 5) == 0) rb[3] = ~rb[3];
      ra[2] = ($urandom_range(0, 2) == 0);
      rb[2] = ($urandom_range(0, 2) == 0);
      ra[1] = ($urandom_range(0, 39) == 0);
      rb[1] = ($urandom_range(0, 29) == 0);
      ra[0] = ($urandom_range(0, 3) == 0);
      rb[0] = ($urandom_range(0, 3) == 0);
      step(ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
